// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX framer and CRC logic.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG,
        DRAIN
    } state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_acc;

    // Fold the byte in LSB first, one polynomial step per bit
    always_comb begin
        crc_acc = crc_in ^ {24'h0, data};
        for (int unsigned i = 0; i < 8; i++) begin
            crc_acc = crc_acc[0] ? ((crc_acc >> 1) ^ CRC_POLY_REFL) : (crc_acc >> 1);
        end
        crc_out = crc_acc;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: drains the TX FIFO and wraps each payload in
// preamble/SFD, pads to minimum length, appends the FCS and holds the IFG.
// Underruns are flagged with tx_er and the rest of that frame is discarded.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int DW           = 8,
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_LEN      = 60,
    parameter int IFG_CYCLES   = 12,
    parameter int CNT_W        = 11
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          fifo_empty,
    input  logic [DW:0]   fifo_data,
    output logic          fifo_rd_en,
    output logic [DW-1:0] gmii_txd,
    output logic          gmii_tx_en,
    output logic          gmii_tx_er,
    output logic          busy,
    output logic          frame_done,
    output logic          underrun
);

    localparam int IDX_MAX0 = (PREAMBLE_LEN > IFG_CYCLES) ? PREAMBLE_LEN : IFG_CYCLES;
    localparam int IDX_MAX  = (IDX_MAX0 > 4) ? IDX_MAX0 : 4;
    localparam int IDX_W    = $clog2(IDX_MAX + 1);

    localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PREAMBLE_LEN - 1);
    localparam logic [IDX_W-1:0] IFG_LAST = IDX_W'(IFG_CYCLES - 1);
    localparam logic [IDX_W-1:0] FCS_LAST = IDX_W'(3);
    localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       crc_q, crc_d;
    logic              rd_vld_q, rd_vld_d;
    logic [DW-1:0]     txd_q, txd_d;
    logic              tx_en_q, tx_en_d;
    logic              tx_er_q, tx_er_d;
    logic              frame_done_q, frame_done_d;
    logic              underrun_q, underrun_d;

    logic              rd_en;
    logic              rd_last;
    logic [CNT_W-1:0]  cnt_inc;
    logic [7:0]        crc_byte;
    logic [31:0]       crc_next;
    logic [31:0]       fcs_word;

    assign rd_last  = rd_vld_q && fifo_data[DW];
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign fcs_word = ~crc_q;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered GMII outputs
    always_ff @(posedge clk) begin
        if (srst) begin
            idx_q        <= '0;
            cnt_q        <= '0;
            crc_q        <= CRC_INIT;
            rd_vld_q     <= 1'b0;
            txd_q        <= '0;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            crc_q        <= crc_d;
            rd_vld_q     <= rd_vld_d;
            txd_q        <= txd_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!fifo_empty) state_d = PRE;
            PRE:   if (idx_q == PRE_LAST) state_d = SFD;
            SFD:   state_d = DATA;
            DATA: begin
                if (!rd_vld_q) begin
                    state_d = DRAIN;
                end else if (fifo_data[DW]) begin
                    state_d = (cnt_inc < MIN_LEN_C) ? PAD : FCS;
                end
            end
            PAD:   if (cnt_inc >= MIN_LEN_C) state_d = FCS;
            FCS:   if (idx_q == FCS_LAST) state_d = IFG;
            IFG:   if (idx_q == IFG_LAST) state_d = IDLE;
            DRAIN: if (rd_last) state_d = IFG;
            default: state_d = IDLE;
        endcase
    end

    // Per-state outputs, FIFO pops, CRC and byte-count updates
    always_comb begin
        idx_d        = (state_d != state_q) ? '0 : idx_q + 1'b1;
        cnt_d        = cnt_q;
        crc_d        = crc_q;
        crc_byte     = '0;
        txd_d        = '0;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        rd_en        = 1'b0;
        case (state_q)
            PRE: begin
                txd_d   = PREAMBLE_BYTE;
                tx_en_d = 1'b1;
            end
            SFD: begin
                txd_d   = SFD_BYTE;
                tx_en_d = 1'b1;
                rd_en   = !fifo_empty;
            end
            DATA: begin
                rd_en   = !fifo_empty && !rd_last;
                tx_en_d = 1'b1;
                if (rd_vld_q) begin
                    txd_d    = fifo_data[DW-1:0];
                    crc_byte = fifo_data[DW-1:0];
                    crc_d    = crc_next;
                    cnt_d    = cnt_inc;
                end else begin
                    tx_er_d    = 1'b1;
                    underrun_d = 1'b1;
                end
            end
            PAD: begin
                tx_en_d = 1'b1;
                crc_d   = crc_next;
                cnt_d   = cnt_inc;
            end
            FCS: begin
                tx_en_d = 1'b1;
                case (idx_q[1:0])
                    2'd0:    txd_d = fcs_word[7:0];
                    2'd1:    txd_d = fcs_word[15:8];
                    2'd2:    txd_d = fcs_word[23:16];
                    default: txd_d = fcs_word[31:24];
                endcase
                frame_done_d = (idx_q == FCS_LAST);
            end
            DRAIN: begin
                rd_en        = !fifo_empty && !rd_last;
                frame_done_d = rd_last;
            end
            default: ;
        endcase
        // Both normal and aborted frames pass through IFG, so reinitialise there
        if (state_d == IFG && state_q != IFG) begin
            crc_d = CRC_INIT;
            cnt_d = '0;
        end
        rd_vld_d = fifo_rd_en;
    end

    // No pop while reset is asserted, so a truncated frame cannot lose a word
    assign fifo_rd_en = rd_en && !srst;
    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_eth_tx_framer.sv
// Randomized self-checking bench for eth_tx_framer with a table-driven
// CRC-32 reference and a queue-based FIFO model.
`timescale 1ns/1ps
module tb_eth_tx_framer;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [8:0] fifo_data = '0;
    logic       fifo_rd_en;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en, gmii_tx_er, busy, frame_done, underrun;

    always #4 clk = ~clk;

    eth_tx_framer #(
        .DW(8), .PREAMBLE_LEN(7), .MIN_LEN(60), .IFG_CYCLES(12), .CNT_W(11)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .gmii_txd   (gmii_txd),
        .gmii_tx_en (gmii_tx_en),
        .gmii_tx_er (gmii_tx_er),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] crc_tbl [256];
    logic [8:0]  fq[$];
    logic [8:0]  held[$];
    logic [7:0]  exp_bytes[$];
    int          exp_len[$];
    int          exp_kind[$];   // 0 good, 1 underrun-aborted, 2 truncated by reset
    logic [7:0]  cur[$];

    int cur_len = 0, er_cnt = 0, er_pos = 0, fd_in = 0, fd_pos = 0, un_pos = 0;
    int frames_seen = 0, low_run = 0, last_gap = 0;
    int rd_cnt = 0, pushed = 0, flushed = 0, n_queued = 0, n_good = 0;
    int rd_when_empty = 0, er_outside = 0, underrun_total = 0, fd_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic build_tbl();
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[n] = c;
        end
    endtask

    // Returns the transmitted FCS value (complemented CRC)
    function automatic logic [31:0] crc_of(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (b[i]) c = crc_tbl[c[7:0] ^ b[i]] ^ (c >> 8);
        return ~c;
    endfunction

    // FIFO model: registered read data, empty flag updated at the clock edge
    always @(posedge clk) begin
        if (srst) begin
            flushed += fq.size();
            fq.delete();
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en) begin
                fifo_data <= fq.pop_front();
                rd_cnt++;
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic finish_frame();
        int len, kind, cmp_len, ncmp, bad;
        logic [7:0]  eb[$];
        logic [31:0] fcs_o, fcs_e;
        if (exp_len.size() == 0) begin
            check("frame_expected", 1, 0);
        end else begin
            len  = exp_len.pop_front();
            kind = exp_kind.pop_front();
            for (int i = 0; i < len; i++) eb.push_back(exp_bytes.pop_front());
            cmp_len = (kind == 0) ? len - 4 : (kind == 1) ? len - 1 : len;
            ncmp = (cur_len < cmp_len) ? cur_len : cmp_len;
            bad = 0;
            for (int i = 0; i < ncmp; i++) if (cur[i] !== eb[i]) bad++;
            check("frame_bytes", bad, 0);
            if (kind == 2) begin
                check("trunc_len", cur_len <= len, 1);
                check("trunc_er", er_cnt, 0);
                check("trunc_done", fd_in, 0);
            end else begin
                check("frame_len", cur_len, len);
                if (kind == 0) begin
                    fcs_o = (cur_len >= 4) ? {cur[cur_len-1], cur[cur_len-2], cur[cur_len-3], cur[cur_len-4]} : '0;
                    fcs_e = {eb[len-1], eb[len-2], eb[len-3], eb[len-4]};
                    check("fcs", fcs_o, fcs_e);
                    check("tx_er_count", er_cnt, 0);
                    check("done_count", fd_in, 1);
                    check("done_pos", fd_pos, len);
                end else begin
                    check("underrun_er_count", er_cnt, 1);
                    check("underrun_er_pos", er_pos, len);
                    check("underrun_pos", un_pos, len);
                    check("aborted_done_in_frame", fd_in, 0);
                end
            end
        end
        frames_seen++;
        cur.delete();
        cur_len = 0; er_cnt = 0; er_pos = 0; fd_in = 0; fd_pos = 0; un_pos = 0;
    endtask

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1 && fifo_empty === 1'b1) rd_when_empty++;
        if (underrun === 1'b1) underrun_total++;
        if (frame_done === 1'b1) fd_total++;
        if (gmii_tx_en === 1'b1) begin
            if (cur_len == 0 && frames_seen > 0) last_gap = low_run;
            low_run = 0;
            cur.push_back(gmii_txd);
            cur_len++;
            if (gmii_tx_er === 1'b1) begin er_cnt++; er_pos = cur_len; end
            if (frame_done === 1'b1) begin fd_in++; fd_pos = cur_len; end
            if (underrun === 1'b1) un_pos = cur_len;
        end else begin
            low_run++;
            if (gmii_tx_er === 1'b1) er_outside++;
            if (cur_len > 0) finish_frame();
        end
    end

    // mode: 0 random bytes, 1 incrementing, 2 constant 0xAB
    task automatic queue_frame(input int n, input int mode, input int kind, input int vis, input int push_now);
        logic [7:0]  p[$], body[$];
        logic [31:0] fcs;
        logic [7:0]  b;
        logic        lastf;
        for (int i = 0; i < n; i++) begin
            b = (mode == 1) ? 8'(i) : (mode == 2) ? 8'hAB : 8'($urandom);
            p.push_back(b);
        end
        body = p;
        while (body.size() < 60) body.push_back(8'h00);
        fcs = crc_of(body);
        for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hD5);
        if (kind == 1) begin
            for (int i = 0; i < vis; i++) exp_bytes.push_back(p[i]);
            exp_bytes.push_back(8'h00);
            exp_len.push_back(8 + vis + 1);
        end else begin
            foreach (body[i]) exp_bytes.push_back(body[i]);
            exp_bytes.push_back(fcs[7:0]);
            exp_bytes.push_back(fcs[15:8]);
            exp_bytes.push_back(fcs[23:16]);
            exp_bytes.push_back(fcs[31:24]);
            exp_len.push_back(8 + body.size() + 4);
            if (kind == 0) n_good++;
        end
        exp_kind.push_back(kind);
        n_queued++;
        for (int i = 0; i < n; i++) begin
            lastf = (i == n - 1);
            if (i < push_now) begin
                fq.push_back({lastf, p[i]});
                pushed++;
            end else begin
                held.push_back({lastf, p[i]});
            end
        end
    endtask

    task automatic push_held();
        while (held.size() > 0) begin
            fq.push_back(held.pop_front());
            pushed++;
        end
    endtask

    task automatic wait_frames();
        int k = 0;
        while (frames_seen < n_queued && k < 6000) begin
            @(negedge clk); #1;
            k++;
        end
        check("wait_frames", frames_seen, n_queued);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic send_random(input int n);
        queue_frame(n, 0, 0, 0, n);
        wait_frames();
        wait_idle();
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] ascii[$];
        string      s;
        int         viol, n1, n2, base_fd, k;

        build_tbl();
        srst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", {gmii_txd, gmii_tx_en, gmii_tx_er, busy, frame_done, underrun, fifo_rd_en}, 0);
        s = "123456789";
        for (int i = 0; i < s.len(); i++) ascii.push_back(s[i]);
        check("crc_model", crc_of(ascii), 32'hCBF43926);
        srst = 1'b0;

        // Idle with an empty FIFO
        viol = 0;
        repeat (100) begin
            @(negedge clk); #1;
            if (fifo_rd_en !== 1'b0 || gmii_tx_en !== 1'b0 || busy !== 1'b0) viol++;
        end
        check("idle_quiet", viol, 0);

        // 64-byte incrementing payload, no pad
        queue_frame(64, 1, 0, 0, 64);
        wait_frames();
        wait_idle();

        // Single byte, padded to 60
        queue_frame(1, 2, 0, 0, 1);
        wait_frames();
        wait_idle();

        // Back-to-back frames
        n1 = $urandom_range(1, 100);
        n2 = $urandom_range(1, 100);
        queue_frame(n1, 0, 0, 0, n1);
        queue_frame(n2, 0, 0, 0, n2);
        wait_frames();
        check("b2b_gap", last_gap, 13);
        wait_idle();

        // Underrun after 10 of 40 bytes, then refill and drain
        base_fd = fd_total;
        queue_frame(40, 0, 1, 10, 10);
        wait_frames();
        repeat (5) @(negedge clk);
        #1;
        check("drain_busy", busy, 1);
        check("drain_no_done", fd_total, base_fd);
        push_held();
        wait_idle();
        check("drain_done", fd_total, base_fd + 1);
        send_random($urandom_range(1, 100));

        // Reset during payload byte 20
        queue_frame(40, 0, 2, 0, 40);
        k = 0;
        while (cur_len < 28 && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        check("wait_byte20", cur_len, 28);
        srst = 1'b1;
        @(negedge clk); #1;
        check("midreset_outs", {gmii_txd, gmii_tx_en, gmii_tx_er, busy, frame_done, underrun, fifo_rd_en}, 0);
        srst = 1'b0;
        wait_frames();
        wait_idle();
        send_random($urandom_range(1, 100));

        // Length boundaries around the pad threshold, and past counter saturation
        send_random(59);
        send_random(60);
        send_random(61);
        send_random(2100);
        for (int i = 0; i < 4; i++) send_random($urandom_range(1, 150));

        repeat (5) @(negedge clk);
        #1;
        check("no_over_read", rd_cnt, pushed - flushed);
        check("rd_while_empty", rd_when_empty, 0);
        check("er_without_en", er_outside, 0);
        check("underrun_pulses", underrun_total, 1);
        check("done_pulses", fd_total, n_good + 1);
        check("exp_left", exp_len.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Downstream consumer of the read side of the MAC TX async FIFO, in the GMII TX clock domain.
- Pops 9-bit FIFO words (bit 8 = last-byte flag, bits 7:0 = payload byte) and emits a complete Ethernet frame on GMII: preamble, SFD, payload, zero pad to minimum length, FCS (CRC-32), then inter-frame gap.
- Detects FIFO underrun mid-frame, flags it on gmii_tx_er, and discards the rest of that frame.

Parameters:
- DW, 8, payload byte width; fixed at 8, with the FIFO word being DW+1 bits.
- PREAMBLE_LEN, 7, number of 0x55 bytes sent before the SFD.
- MIN_LEN, 60, minimum payload-plus-pad byte count, excluding the FCS.
- IFG_CYCLES, 12, idle cycles after the last FCS byte.
- CNT_W, 11, width of the byte counter; saturates, does not wrap.

Ports:
- clk  in  1  GMII TX clock (125 MHz); the FIFO read clock is the same net.
- srst  in  1  synchronous reset, active-high.
- fifo_empty  in  1  FIFO empty flag, rclk domain.
- fifo_data  in  DW+1  FIFO read data, valid 1 cycle after fifo_rd_en; bit 8 = last.
- fifo_rd_en  out  1  FIFO pop; combinational.
- gmii_txd  out  DW  GMII transmit data; registered.
- gmii_tx_en  out  1  GMII transmit enable; registered.
- gmii_tx_er  out  1  GMII transmit error; registered.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on the last FCS byte (or the aborted frame's last cycle).
- underrun  out  1  one-cycle pulse when an underrun is detected.

Interface (already decided): one clock; reset is synchronous and active-high (ports clk, srst; polarity and synchronicity fixed).

Behaviour:
- Reset: state=IDLE; all outputs 0; counters 0; CRC = 0xFFFFFFFF. A reset mid-frame takes effect the next edge and truncates the frame (tx_en drops, no FCS).
- FSM states: IDLE -> PRE -> SFD -> DATA -> PAD -> FCS -> IFG -> IDLE, plus DRAIN for underrun.
- IDLE:
  - If !fifo_empty, go to PRE.
  - No pop in IDLE.
- PRE: PREAMBLE_LEN cycles of txd=0x55, tx_en=1.
- SFD: one cycle of txd=0xD5. fifo_rd_en = !fifo_empty in this cycle (prefetch).
- Read latency: rd_vld_q = fifo_rd_en delayed by 1 cycle. fifo_data is consumed only when rd_vld_q=1.
- DATA:
  - Each cycle with rd_vld_q=1: output the byte, update the CRC, increment the byte count.
  - fifo_rd_en = !fifo_empty && !(rd_vld_q && fifo_data[8]). The cycle that returns the last byte therefore never issues a further pop, so there is no over-read.
  - After the last byte: go to PAD if count < MIN_LEN, else go to FCS.
- Underrun: in DATA, rd_vld_q=0 (the previous cycle's pop was blocked by empty) ->
  - gmii_tx_er=1 with tx_en=1 for that cycle; underrun pulses; go to DRAIN.
- DRAIN:
  - tx_en=0.
  - Pop whenever !fifo_empty until a word with bit 8=1 returns, then go to IFG.
  - frame_done pulses on that cycle; no FCS is sent.
- PAD: send 0x00 bytes (included in the CRC) until count == MIN_LEN, then go to FCS.
- FCS:
  - 4 bytes of ~CRC, least-significant byte first (reflected CRC-32, polynomial 0x04C11DB7).
  - frame_done pulses with the 4th byte.
- IFG: tx_en=0, txd=0 for IFG_CYCLES, then IDLE. The CRC and count are reinitialised on entry to IFG.
- Pipeline: gmii_* are registered, i.e. one cycle after the state/data decision. The first 0x55 appears 2 cycles after IDLE sees !fifo_empty.
- Back-to-back frames: IDLE with a non-empty FIFO goes straight to PRE, giving a minimum gap of exactly IFG_CYCLES+1 idle cycles on tx_en.
- Counter saturates at 2^CNT_W-1; frames longer than that are still sent unchanged.
- fifo_rd_en is never asserted when fifo_empty=1.

Decomposition:
- Package eth_pkg:
  - state enum typedef (IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN);
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_INIT=32'hFFFFFFFF, CRC_POLY_REFL=32'hEDB88320.
- One sub-module, crc32_d8: combinational next-CRC from (crc_in[31:0], data[7:0]), reused by the RX checker.

Test Plan:
- 64-byte payload 0x00..0x3F, last on 0x3F -> 7×0x55, 0xD5, 64 bytes in order, 4 FCS bytes matching the reference model; no pad; frame_done on the 76th tx_en cycle; tx_er never asserted.
- 1-byte payload 0xAB -> 0xAB followed by 59×0x00 pad, then FCS over 60 bytes; tx_en high for exactly 72 cycles.
- Two frames queued back-to-back -> tx_en low for exactly 13 cycles between them; fifo_rd_en count equals total payload words (no over-read).
- FIFO empties after 10 of 40 bytes -> tx_er=1 for 1 cycle, underrun pulse, tx_en drops; remaining 30 words drained once refilled; the next frame transmits cleanly.
- srst asserted during DATA byte 20 -> next cycle all outputs 0, state IDLE; the next frame has a correct CRC (no stale state).
- fifo_empty held high in IDLE for 100 cycles -> fifo_rd_en, tx_en and busy stay 0.
